// File: rtl/bram_mp_pkg.sv
// Shared types and helpers for the multi-port block RAM with clear sequencer.
package bram_mp_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Widest word the parity helper accepts; callers zero-extend into it.
    localparam int unsigned PAR_MAX_W = 1024;

    function automatic logic par_even(input logic [PAR_MAX_W-1:0] data);
        return ^data;
    endfunction

    function automatic int unsigned slice_lo(input int unsigned idx, input int unsigned width);
        return idx * width;
    endfunction

endpackage

// File: rtl/bram_mp_init_seq.sv
// Clear sequencer: sweeps every address once after reset or CLEAR, then holds RUN.
module bram_mp_init_seq
    import bram_mp_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 32
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_clear,
    output logic              o_ready,
    output logic              o_sweep_we,
    output logic [ADDR_W-1:0] o_sweep_addr,
    output logic              o_busy
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_cnt;
    logic [ADDR_W-1:0] w_cnt_nxt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_INIT;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_INIT: begin
                if (i_clear) begin
                    w_cnt_nxt = '0;
                end else if (r_cnt == LAST) begin
                    w_state_nxt = ST_RUN;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            ST_RUN: begin
                if (i_clear) begin
                    w_state_nxt = ST_INIT;
                    w_cnt_nxt   = '0;
                end
            end
            default: ;
        endcase
    end

    assign o_ready      = (r_state == ST_RUN);
    assign o_busy       = (r_state == ST_INIT);
    assign o_sweep_we   = (r_state == ST_INIT);
    assign o_sweep_addr = r_cnt;

endmodule

// File: rtl/bram_mp_init.sv
// NUM_RD-read / 1-write block RAM with hardware clear sweep and selectable collision mode.
// Define BRAM_MP_PARITY_EN to store an even-parity bit per word and report read parity errors.
module bram_mp_init
    import bram_mp_pkg::*;
#(
    parameter int ADDR_W      = 5,
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 32,
    parameter int NUM_RD      = 3,
    parameter int WRITE_FIRST = 0
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     CLEAR,
    output logic                     READY,
    input  logic                     WR_EN,
    input  logic [ADDR_W-1:0]        WR_ADDR,
    input  logic [DATA_W-1:0]        WR_VAL,
    input  logic [NUM_RD-1:0]        RD_EN,
    input  logic [NUM_RD*ADDR_W-1:0] RD_ADDR,
    output logic [NUM_RD*DATA_W-1:0] DOUT,
    output logic [NUM_RD-1:0]        DOUT_RDY,
    output logic [NUM_RD-1:0]        DOUT_PERR
);

`ifdef BRAM_MP_PARITY_EN
    localparam int MEM_W = DATA_W + 1;
`else
    localparam int MEM_W = DATA_W;
`endif
    localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);

    logic [MEM_W-1:0]  r_mem [DEPTH];
    logic              w_sweep_we;
    logic [ADDR_W-1:0] w_sweep_addr;
    logic              w_busy;
    logic              w_we;
    logic [ADDR_W-1:0] w_wa;
    logic [MEM_W-1:0]  w_wd;
    logic [MEM_W-1:0]  w_user_wd;

    bram_mp_init_seq #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_seq (
        .i_clk        (CLK),
        .i_rst        (RST),
        .i_clear      (CLEAR),
        .o_ready      (READY),
        .o_sweep_we   (w_sweep_we),
        .o_sweep_addr (w_sweep_addr),
        .o_busy       (w_busy)
    );

`ifdef BRAM_MP_PARITY_EN
    assign w_user_wd = {par_even(PAR_MAX_W'(WR_VAL)), WR_VAL};
`else
    assign w_user_wd = WR_VAL;
`endif

    // The sweep owns the write port while busy; user writes to out-of-range addresses are dropped.
    always_comb begin
        w_we = 1'b0;
        w_wa = WR_ADDR;
        w_wd = w_user_wd;
        if (w_busy) begin
            w_we = w_sweep_we;
            w_wa = w_sweep_addr;
            w_wd = '0;
        end else begin
            w_we = WR_EN && ({1'b0, WR_ADDR} < DEPTH_X);
        end
    end

    always_ff @(posedge CLK) begin
        if (w_we) begin
            r_mem[w_wa] <= w_wd;
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] w_ra;
        logic              w_in;
        logic              w_rd;
        logic              w_perr;
        logic [MEM_W-1:0]  w_word;
        logic [DATA_W-1:0] r_dout;
        logic              r_rdy;
        logic              r_perr;

        assign w_ra = RD_ADDR[slice_lo(i, ADDR_W) +: ADDR_W];
        assign w_in = ({1'b0, w_ra} < DEPTH_X);
        assign w_rd = RD_EN[i] && !w_busy;

        always_comb begin
            w_word = '0;
            if (w_in) begin
                if ((WRITE_FIRST != 0) && w_we && (w_wa == w_ra)) begin
                    w_word = w_wd;
                end else begin
                    w_word = r_mem[w_ra];
                end
            end
        end

`ifdef BRAM_MP_PARITY_EN
        assign w_perr = w_in && (par_even(PAR_MAX_W'(w_word[DATA_W-1:0])) != w_word[DATA_W]);
`else
        assign w_perr = 1'b0;
`endif

        always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
                r_dout <= '0;
                r_rdy  <= 1'b0;
                r_perr <= 1'b0;
            end else begin
                r_rdy  <= w_rd;
                r_perr <= w_rd && w_perr;
                if (w_rd) begin
                    r_dout <= w_word[DATA_W-1:0];
                end
            end
        end

        assign DOUT[slice_lo(i, DATA_W) +: DATA_W] = r_dout;
        assign DOUT_RDY[i]  = r_rdy;
        assign DOUT_PERR[i] = r_perr;
    end

endmodule
